// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
//
// Direct-mapped instruction cache with single-word lines, sitting directly
// upstream of InstructionFetch. Every cycle the fetch address is looked up.
// The result appears one cycle later on Instr_valid/Instr. A miss issues
// exactly one word read to the memory controller, then fills the line when
// the word returns. A ROB redirect (jump_wrong) invalidates the current
// lookup. An outstanding memory read cannot be cancelled, so a redirect
// during a miss still lets the fill land in the array.
//
// Optional feature macro: ICACHE_FORWARD_EN
//   defined   - a returning fill whose word address matches the current
//               next_pc is forwarded straight to Instr on the fill edge.
//   undefined - the fill edge always drops Instr_valid. The word is picked
//               up by the ordinary hit path on the next lookup.
//
// Parameters
//   ICACHE_INDEX_BITS : log2 of the line count (index = addr[N+1:2],
//                       tag = addr[31:N+2])
//
// Ports
//   clk          in   single clock, all state changes on posedge
//   rst          in   synchronous active-high reset
//   rdy          in   global enable; low freezes FSM, array and outputs
//   jump_wrong   in   ROB redirect, current lookup is not trustworthy
//   next_pc      in   fetch address, bits [1:0] ignored
//   Instr_valid  out  Instr holds the word looked up in the previous cycle
//   Instr        out  instruction word
//   MC_req       out  level read request to the memory controller
//   MC_addr      out  word-aligned request address
//   MC_valid     in   one-cycle pulse, MC_data holds the returned word
//   MC_data      in   returned word
// ---------------------------------------------------------------------------
module icache #(
    parameter int ICACHE_INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        jump_wrong,
    input  logic [31:0] next_pc,
    output logic        Instr_valid,
    output logic [31:0] Instr,
    output logic        MC_req,
    output logic [31:0] MC_addr,
    input  logic        MC_valid,
    input  logic [31:0] MC_data
);

    localparam int LINES    = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_BITS = 30 - ICACHE_INDEX_BITS;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;

    // Line storage. Only the valid bits need a reset. Tags and data are
    // qualified by the valid bit, so they can live in plain RAM.
    logic [LINES-1:0]    line_valid;
    logic [TAG_BITS-1:0] line_tag  [LINES];
    logic [31:0]         line_data [LINES];

    logic [ICACHE_INDEX_BITS-1:0] lookup_index;
    logic [TAG_BITS-1:0]          lookup_tag;
    logic                         lookup_hit;
    logic [ICACHE_INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]          fill_tag;
    logic                         forward_hit;
    logic                         fill_en;

    logic        instr_valid_next;
    logic [31:0] instr_next;
    logic        mc_req_next;
    logic [31:0] mc_addr_next;

    // The byte offset of the fetch address plays no role anywhere.
    logic unused_pc_bits;
    assign unused_pc_bits = ^next_pc[1:0];

    assign lookup_index = next_pc[ICACHE_INDEX_BITS+1:2];
    assign lookup_tag   = next_pc[31:ICACHE_INDEX_BITS+2];
    assign lookup_hit   = line_valid[lookup_index]
                          && (line_tag[lookup_index] == lookup_tag);

    // The fill target is always the outstanding request address. It stays
    // stable for the whole miss, even if next_pc wanders off after a
    // redirect.
    assign fill_index = MC_addr[ICACHE_INDEX_BITS+1:2];
    assign fill_tag   = MC_addr[31:ICACHE_INDEX_BITS+2];

`ifdef ICACHE_FORWARD_EN
    // Forward only when the returning word is the one being fetched right
    // now. A redirect in the same cycle makes next_pc meaningless.
    assign forward_hit = !jump_wrong && (MC_addr[31:2] == next_pc[31:2]);
`else
    assign forward_hit = 1'b0;
`endif

    // Next-state and next-output decode. Everything defaults to holding,
    // which also gives the rdy=0 freeze for free.
    always_comb begin
        state_next       = state;
        instr_valid_next = Instr_valid;
        instr_next       = Instr;
        mc_req_next      = MC_req;
        mc_addr_next     = MC_addr;
        fill_en          = 1'b0;

        if (rdy) begin
            case (state)
                IDLE: begin
                    if (jump_wrong) begin
                        instr_valid_next = 1'b0;
                    end else if (lookup_hit) begin
                        instr_valid_next = 1'b1;
                        instr_next       = line_data[lookup_index];
                    end else begin
                        instr_valid_next = 1'b0;
                        mc_req_next      = 1'b1;
                        mc_addr_next     = {next_pc[31:2], 2'b00};
                        state_next       = WAIT;
                    end
                end

                WAIT: begin
                    instr_valid_next = 1'b0;
                    if (MC_valid) begin
                        fill_en     = 1'b1;
                        mc_req_next = 1'b0;
                        state_next  = IDLE;
                        if (forward_hit) begin
                            instr_valid_next = 1'b1;
                            instr_next       = MC_data;
                        end
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers, plus the valid bits. Reset drops any
    // outstanding miss. The memory controller is reset alongside, so
    // nothing comes back for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            Instr_valid <= 1'b0;
            Instr       <= 32'h0;
            MC_req      <= 1'b0;
            MC_addr     <= 32'h0;
            line_valid  <= '0;
        end else begin
            state       <= state_next;
            Instr_valid <= instr_valid_next;
            Instr       <= instr_next;
            MC_req      <= mc_req_next;
            MC_addr     <= mc_addr_next;
            if (fill_en) begin
                line_valid[fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data array write port. The valid bit above gates these
    // entries, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            line_tag[fill_index]  <= fill_tag;
            line_data[fill_index] <= MC_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
//
// Self-checking bench for icache. The reference model holds the cache
// contents as a set of resident word addresses. It evicts any word that
// shares an index with an incoming fill, and it derives every instruction
// word from a fixed memory function. A memory responder returns each read
// after a chosen latency, only while rdy is high.
// ---------------------------------------------------------------------------
module tb_icache;

    localparam int IDX = 8;
`ifdef ICACHE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        jump_wrong;
    logic [31:0] next_pc;
    logic        Instr_valid;
    logic [31:0] Instr;
    logic        MC_req;
    logic [31:0] MC_addr;
    logic        MC_valid;
    logic [31:0] MC_data;

    always #5 clk = ~clk;

    icache #(.ICACHE_INDEX_BITS(IDX)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .jump_wrong  (jump_wrong),
        .next_pc     (next_pc),
        .Instr_valid (Instr_valid),
        .Instr       (Instr),
        .MC_req      (MC_req),
        .MC_addr     (MC_addr),
        .MC_valid    (MC_valid),
        .MC_data     (MC_data)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Reference model state
    bit          cached [logic [31:0]];
    bit          waiting   = 1'b0;
    int          wait_cnt  = 0;
    int          cur_lat   = 1;
    int          mem_lat   = 3;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_instr = 32'h0;
    logic        exp_req   = 1'b0;
    logic [31:0] exp_addr  = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0513;
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) % (1 << IDX));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                      name, act, exp, $time);
    endtask

    // Drive one cycle of inputs just after the falling edge. Update the
    // model for the coming rising edge. Return 1 time unit after that edge.
    task automatic applyStimulus(input bit r, input bit rd, input bit jw,
                                 input logic [31:0] pc);
        logic        mcv;
        logic [31:0] mcd;
        logic [31:0] w;
        logic [31:0] victims [$];
        @(negedge clk);
        #1;
        mcv = 1'b0;
        mcd = $urandom;
        if (!r && rd && waiting) begin
            wait_cnt++;
            if (wait_cnt >= cur_lat) begin
                mcv = 1'b1;
                mcd = mem_word(exp_addr);
            end
        end
        rst        = r;
        rdy        = rd;
        jump_wrong = jw;
        next_pc    = pc;
        MC_valid   = mcv;
        MC_data    = mcd;

        w = {pc[31:2], 2'b00};
        if (r) begin
            cached.delete();
            waiting   = 1'b0;
            exp_valid = 1'b0;
            exp_instr = 32'h0;
            exp_req   = 1'b0;
            exp_addr  = 32'h0;
        end else if (rd) begin
            if (!waiting) begin
                if (jw) begin
                    exp_valid = 1'b0;
                end else if (cached.exists(w)) begin
                    exp_valid = 1'b1;
                    exp_instr = mem_word(w);
                end else begin
                    exp_valid = 1'b0;
                    exp_req   = 1'b1;
                    exp_addr  = w;
                    waiting   = 1'b1;
                    wait_cnt  = 0;
                    cur_lat   = mem_lat;
                end
            end else begin
                exp_valid = 1'b0;
                if (mcv) begin
                    foreach (cached[k])
                        if (line_of(k) == line_of(exp_addr)) victims.push_back(k);
                    foreach (victims[i]) cached.delete(victims[i]);
                    cached[exp_addr] = 1'b1;
                    exp_req = 1'b0;
                    waiting = 1'b0;
                    if (FWD && !jw && exp_addr[31:2] == pc[31:2]) begin
                        exp_valid = 1'b1;
                        exp_instr = mem_word(exp_addr);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Run until the outstanding miss returns. Without forwarding, run one
    // more lookup so the word arrives through the hit path.
    task automatic waitFill(input logic [31:0] pc);
        int guard;
        guard = 0;
        while (waiting && guard < 50) begin
            applyStimulus(1'b0, 1'b1, 1'b0, pc);
            guard++;
        end
        checkOutput("fill_done", {31'h0, waiting}, 32'h0);
        if (!FWD) applyStimulus(1'b0, 1'b1, 1'b0, pc);
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("Instr_valid", {31'h0, Instr_valid}, {31'h0, exp_valid});
            checkOutput("MC_req", {31'h0, MC_req}, {31'h0, exp_req});
            checkOutput("MC_addr", MC_addr, exp_addr);
            if (exp_valid) checkOutput("Instr", Instr, exp_instr);
        end
    end

    initial begin
        logic [31:0] pool [8];
        logic [31:0] pc;
        pool[0] = 32'h0000_0000; pool[1] = 32'h0000_0400;
        pool[2] = 32'h0000_0800; pool[3] = 32'h0000_0010;
        pool[4] = 32'h0000_0080; pool[5] = 32'h0000_0410;
        pool[6] = 32'h0000_03FC; pool[7] = 32'hFFFF_FFFC;
        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0; next_pc = 32'h0;
        MC_valid = 1'b0; MC_data = 32'h0;

        // Reset state
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        check_en = 1'b1;
        checkOutput("rst_Instr_valid", {31'h0, Instr_valid}, 32'h0);
        checkOutput("rst_Instr", Instr, 32'h0);
        checkOutput("rst_MC_req", {31'h0, MC_req}, 32'h0);
        checkOutput("rst_MC_addr", MC_addr, 32'h0);

        // Cold miss at 0, latency 3
        mem_lat = 3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cold_req", {31'h0, MC_req}, 32'h1);
        checkOutput("cold_addr", MC_addr, 32'h0);
        waitFill(32'h0);
        checkOutput("cold_valid", {31'h0, Instr_valid}, 32'h1);
        checkOutput("cold_instr", Instr, 32'h0000_0513);
        checkOutput("cold_req_drop", {31'h0, MC_req}, 32'h0);

        // Hit after fill; misaligned low bits ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("hit_valid", {31'h0, Instr_valid}, 32'h1);
        checkOutput("hit_instr", Instr, 32'h0000_0513);
        checkOutput("hit_no_req", {31'h0, MC_req}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h3);
        checkOutput("misalign_instr", Instr, 32'h0000_0513);

        // Redirect in IDLE suppresses a hit
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
        checkOutput("jw_idle_valid", {31'h0, Instr_valid}, 32'h0);
        checkOutput("jw_idle_req", {31'h0, MC_req}, 32'h0);

        // Conflict eviction: 0x400 shares index 0 with 0x0
        mem_lat = 2;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h400);
        checkOutput("conf_addr", MC_addr, 32'h400);
        waitFill(32'h400);
        checkOutput("conf_instr", Instr, mem_word(32'h400));
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("evict_req", {31'h0, MC_req}, 32'h1);
        checkOutput("evict_addr", MC_addr, 32'h0);
        waitFill(32'h0);

        // Redirect during WAIT on 0x10, fetch moves to 0x80
        mem_lat = 4;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10);
        checkOutput("jw_wait_addr", MC_addr, 32'h10);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h80);
        checkOutput("jw_wait_valid", {31'h0, Instr_valid}, 32'h0);
        for (int i = 0; i < 10 && waiting; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'h80);
        checkOutput("jw_fill_valid", {31'h0, Instr_valid}, 32'h0);
        checkOutput("jw_fill_req", {31'h0, MC_req}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h80);
        checkOutput("jw_new_req", {31'h0, MC_req}, 32'h1);
        checkOutput("jw_new_addr", MC_addr, 32'h80);
        waitFill(32'h80);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h10);
        checkOutput("jw_line10_hit", {31'h0, Instr_valid}, 32'h1);
        checkOutput("jw_line10_instr", Instr, mem_word(32'h10));

        // rdy low for 5 cycles mid-WAIT
        mem_lat = 3;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h200);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h200);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h200);
            checkOutput("stall_req", {31'h0, MC_req}, 32'h1);
            checkOutput("stall_addr", MC_addr, 32'h200);
            checkOutput("stall_valid", {31'h0, Instr_valid}, 32'h0);
        end
        waitFill(32'h200);
        checkOutput("stall_instr", Instr, mem_word(32'h200));

        // Reset mid-WAIT wipes the array
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("pre_rst_hit", {31'h0, Instr_valid}, 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h300);
        checkOutput("rst_wait_req", {31'h0, MC_req}, 32'h0);
        checkOutput("rst_wait_valid", {31'h0, Instr_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("post_rst_miss", {31'h0, MC_req}, 32'h1);
        checkOutput("post_rst_addr", MC_addr, 32'h0);
        waitFill(32'h0);

        // Randomized traffic
        pc = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            mem_lat = int'($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 0)
                pc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 99) < 85,
                          $urandom_range(0, 9) == 0, pc);
        end

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
